// File: rtl/bus_slot_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_slot_pkg
// Shared constants for the bus slot arbiter and its phase generator.
// The phase numbers name the fixed slots inside one bus frame. Phases between
// PH_DMA_CAP and the step phase are idle. The step phase is always the last
// phase of the frame.
// -----------------------------------------------------------------------------
package bus_slot_pkg;

   localparam int PH_W        = 4;
   localparam int DIVIDER_MIN = 4;
   localparam int DIVIDER_MAX = 16;

   localparam logic [PH_W-1:0] PH_CPU_ACC = 4'd0;
   localparam logic [PH_W-1:0] PH_CPU_CAP = 4'd1;
   localparam logic [PH_W-1:0] PH_DMA_ACC = 4'd2;
   localparam logic [PH_W-1:0] PH_DMA_CAP = 4'd3;

   // Index of the last phase in a frame. The CPU strobe is visible during it.
   function automatic logic [PH_W-1:0] ph_step(input int divider);
      return PH_W'(divider - 1);
   endfunction

endpackage

// File: rtl/bus_slot_arbiter_phase_gen.sv
// -----------------------------------------------------------------------------
// bus_phase_gen
// Frame phase counter. It counts 0..DIVIDER-1 and wraps back to 0.
// A synchronous reset returns it to phase 0, so the first cycle after
// reset release is always the CPU access slot.
//
// Ports
//   clk      : system clock
//   rst      : synchronous active-high reset
//   phase    : current phase within the bus frame
//   cpu_acc  : phase 0 decode (CPU memory slot)
//   cpu_cap  : phase 1 decode (CPU read capture, DMA request sample)
//   dma_acc  : phase 2 decode (DMA memory slot)
//   dma_cap  : phase 3 decode (DMA read capture)
// -----------------------------------------------------------------------------
module bus_phase_gen
   import bus_slot_pkg::*;
#(
   parameter int DIVIDER = 4
) (
   input  logic            clk,
   input  logic            rst,
   output logic [PH_W-1:0] phase,
   output logic            cpu_acc,
   output logic            cpu_cap,
   output logic            dma_acc,
   output logic            dma_cap
);

   localparam logic [PH_W-1:0] LAST = ph_step(DIVIDER);

   // Free-running frame counter; wraps on the last phase of the frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= '0;
      end else if (phase == LAST) begin
         phase <= '0;
      end else begin
         phase <= phase + 1'b1;
      end
   end

   // One-hot decode of the fixed slot phases straight from the counter.
   always_comb begin
      cpu_acc = (phase == PH_CPU_ACC);
      cpu_cap = (phase == PH_CPU_CAP);
      dma_acc = (phase == PH_DMA_ACC);
      dma_cap = (phase == PH_DMA_CAP);
   end

endmodule

// File: rtl/bus_slot_arbiter.sv
// -----------------------------------------------------------------------------
// bus_slot_arbiter
// Shares one synchronous single-port memory between the 6502 CPU wrapper and
// a DMA/video requester. Each requester gets one fixed slot per bus frame of
// DIVIDER clocks. The block also produces the wrapper enable/ready strobes.
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   cpu_enable, cpu_ready         : one-clock step strobe in the last phase
//   cpu_ab, cpu_dbo, cpu_we       : CPU address, write data, write enable
//   cpu_dbi                       : registered CPU read data
//   cpu_halt                      : freeze request, sampled at phase 0
//   dma_req, dma_addr, dma_we,
//   dma_wdata                     : DMA request (level held) and access
//   dma_ack                       : pulse in the cycle the DMA access is on
//                                   the memory bus
//   dma_rdata, dma_rvalid         : DMA read data, loaded from the memory on
//                                   the phase-3 edge and seen the next clock
//   mem_addr, mem_we, mem_wdata   : memory request (combinational slot mux)
//   mem_rdata                     : memory read data, one clock after address
// -----------------------------------------------------------------------------
module bus_slot_arbiter
   import bus_slot_pkg::*;
#(
   parameter int DIVIDER = 4,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic              cpu_enable,
   output logic              cpu_ready,
   input  logic [ADDR_W-1:0] cpu_ab,
   input  logic [DATA_W-1:0] cpu_dbo,
   input  logic              cpu_we,
   output logic [DATA_W-1:0] cpu_dbi,
   input  logic              cpu_halt,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic              dma_we,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [PH_W-1:0] PH_STEP     = ph_step(DIVIDER);
   localparam logic [PH_W-1:0] PH_PRE_STEP = PH_STEP - 1'b1;

   logic [PH_W-1:0]   phase;
   logic              cpu_acc;
   logic              cpu_cap;
   logic              dma_acc;
   logic              dma_cap;
   logic              cpu_slot;
   logic              dma_slot;
   logic              halted;
   logic              dma_grant;
   logic              dma_rd_pend;
   logic [ADDR_W-1:0] addr_hold;
   logic [DATA_W-1:0] wdata_hold;

   bus_phase_gen #(
      .DIVIDER (DIVIDER)
   ) u_phase_gen (
      .clk     (clk),
      .rst     (rst),
      .phase   (phase),
      .cpu_acc (cpu_acc),
      .cpu_cap (cpu_cap),
      .dma_acc (dma_acc),
      .dma_cap (dma_cap)
   );

   assign cpu_slot = cpu_acc;
   assign dma_slot = dma_acc & dma_grant;

   // Memory request mux. The halt request is used directly in the CPU slot
   // because it is sampled in that same cycle: a frame that starts halted
   // must not write. Idle phases replay the last address with no write.
   // Reset forces the bus quiet so an aborted access cannot write.
   always_comb begin
      mem_addr  = addr_hold;
      mem_wdata = wdata_hold;
      mem_we    = 1'b0;
      if (rst) begin
         mem_addr  = '0;
         mem_wdata = '0;
      end else if (cpu_slot) begin
         mem_addr  = cpu_ab;
         mem_wdata = cpu_dbo;
         mem_we    = cpu_we & ~cpu_halt;
      end else if (dma_slot) begin
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         mem_we    = dma_we;
      end
   end

   // Remember the last driven address/data so idle phases hold them.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_hold  <= '0;
         wdata_hold <= '0;
      end else if (cpu_slot) begin
         addr_hold  <= cpu_ab;
         wdata_hold <= cpu_dbo;
      end else if (dma_slot) begin
         addr_hold  <= dma_addr;
         wdata_hold <= dma_wdata;
      end
   end

   // Halt is latched once per frame in the CPU slot. The DMA request is
   // latched in phase 1. Requests that arrive later wait for the next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         halted    <= 1'b0;
         dma_grant <= 1'b0;
      end else begin
         if (cpu_acc) begin
            halted <= cpu_halt;
         end
         if (cpu_cap) begin
            dma_grant <= dma_req;
         end
      end
   end

   // CPU side. Read data is captured in phase 1. The step strobe is loaded
   // one phase early so it is visible during the last phase. The wrapper
   // then advances on the frame's final edge and has its next address
   // ready for phase 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_dbi    <= '0;
         cpu_enable <= 1'b0;
         cpu_ready  <= 1'b0;
      end else begin
         if (cpu_cap && !halted) begin
            cpu_dbi <= mem_rdata;
         end
         cpu_enable <= (phase == PH_PRE_STEP) && !halted;
         cpu_ready  <= (phase == PH_PRE_STEP) && !halted;
      end
   end

   // DMA side. The ack is loaded on the grant edge so it coincides with the
   // DMA slot. dma_rd_pend marks that the slot just issued was a read, and
   // its data is captured in the following phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         dma_ack     <= 1'b0;
         dma_rd_pend <= 1'b0;
         dma_rvalid  <= 1'b0;
         dma_rdata   <= '0;
      end else begin
         dma_ack     <= cpu_cap && dma_req;
         dma_rd_pend <= dma_slot && !dma_we;
         dma_rvalid  <= dma_cap && dma_rd_pend;
         if (dma_cap && dma_rd_pend) begin
            dma_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_bus_slot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_slot_arbiter
// Frame-level bench for bus_slot_arbiter. A DIVIDER=4 instance runs against a
// behavioural memory. A reference memory image predicts each CPU step's read
// data, each memory write, each DMA ack and each DMA read result. A monitor
// matches those against DUT events. A DIVIDER=8 instance runs alongside to
// check the longer frame timing.
// -----------------------------------------------------------------------------
module tb_bus_slot_arbiter;
   import bus_slot_pkg::*;

   localparam int DIV  = 4;
   localparam int DIV8 = 8;
   localparam int AW   = 16;
   localparam int DW   = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   logic          cpuEnable, cpuReady, cpuWe, cpuHalt;
   logic          dmaReq, dmaWe, dmaAck, dmaRvalid, memWe;
   logic [AW-1:0] cpuAb, dmaAddr, memAddr;
   logic [DW-1:0] cpuDbo, cpuDbi, dmaWdata, dmaRdata, memWdata, memRdata;

   logic          d8Enable, d8Ready, d8Ack, d8Rvalid, d8MemWe;
   logic          d8CpuWe, d8Halt, d8Req, d8DmaWe;
   logic [AW-1:0] d8MemAddr;
   logic [DW-1:0] d8Dbi, d8Rdata, d8MemWdata, d8MemRdata;

   bus_slot_arbiter #(.DIVIDER(DIV), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .cpu_enable(cpuEnable), .cpu_ready(cpuReady),
      .cpu_ab(cpuAb), .cpu_dbo(cpuDbo), .cpu_we(cpuWe), .cpu_dbi(cpuDbi),
      .cpu_halt(cpuHalt),
      .dma_req(dmaReq), .dma_addr(dmaAddr), .dma_we(dmaWe), .dma_wdata(dmaWdata),
      .dma_ack(dmaAck), .dma_rdata(dmaRdata), .dma_rvalid(dmaRvalid),
      .mem_addr(memAddr), .mem_we(memWe), .mem_wdata(memWdata), .mem_rdata(memRdata)
   );

   bus_slot_arbiter #(.DIVIDER(DIV8), .ADDR_W(AW), .DATA_W(DW)) dut8 (
      .clk(clk), .rst(rst),
      .cpu_enable(d8Enable), .cpu_ready(d8Ready),
      .cpu_ab(cpuAb), .cpu_dbo(cpuDbo), .cpu_we(d8CpuWe), .cpu_dbi(d8Dbi),
      .cpu_halt(d8Halt),
      .dma_req(d8Req), .dma_addr(dmaAddr), .dma_we(d8DmaWe), .dma_wdata(dmaWdata),
      .dma_ack(d8Ack), .dma_rdata(d8Rdata), .dma_rvalid(d8Rvalid),
      .mem_addr(d8MemAddr), .mem_we(d8MemWe), .mem_wdata(d8MemWdata), .mem_rdata(d8MemRdata)
   );

   // Behavioural synchronous memory (read-old on a same-address write).
   logic [DW-1:0] ram    [0:65535];
   logic [DW-1:0] refMem [0:65535];

   always @(posedge clk) begin
      memRdata <= ram[memAddr];
      if (memWe) begin
         ram[memAddr] <= memWdata;
      end
   end

   // Cycles since reset release; phase is this count modulo the frame length.
   int tbCycle = 0;
   always @(posedge clk) begin
      if (rst) begin
         tbCycle <= 0;
      end else begin
         tbCycle <= tbCycle + 1;
      end
   end

   int  assertCount = 0;
   int  failCount   = 0;
   bit  monOn       = 1'b0;
   bit  d8On        = 1'b0;
   logic [DW-1:0] lastDbi = '0;

   logic [DW-1:0] cpuQ  [$];
   logic [23:0]   wrQ   [$];
   logic [AW-1:0] ackQ  [$];
   logic [DW-1:0] rdQ   [$];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [DW-1:0] initVal(input int a);
      return DW'((a * 37) ^ (a >> 8) ^ 11);
   endfunction

   // Monitor: every DUT event consumes the next predicted value for its kind.
   always @(negedge clk) begin
      int ph;
      if (monOn && !rst) begin
         ph = tbCycle % DIV;
         if (cpuEnable || cpuReady) begin
            checkOutput("ready_matches_enable", cpuReady, cpuEnable);
            checkOutput("step_phase", ph, DIV - 1);
            checkOutput("step_pending", cpuQ.size() > 0, 1);
            if (cpuQ.size() > 0) begin
               checkOutput("cpu_read_data", cpuDbi, cpuQ.pop_front());
            end
         end
         if (memWe) begin
            checkOutput("write_slot_phase", (ph == 0) || (ph == 2), 1);
            checkOutput("write_pending", wrQ.size() > 0, 1);
            if (wrQ.size() > 0) begin
               checkOutput("mem_write", {memAddr, memWdata}, wrQ.pop_front());
            end
         end
         if (dmaAck) begin
            checkOutput("ack_phase", ph, 2);
            checkOutput("ack_pending", ackQ.size() > 0, 1);
            if (ackQ.size() > 0) begin
               checkOutput("ack_addr", memAddr, ackQ.pop_front());
            end
         end
         if (dmaRvalid) begin
            checkOutput("rvalid_phase", ph, (3 + 1) % DIV);
            checkOutput("rvalid_pending", rdQ.size() > 0, 1);
            if (rdQ.size() > 0) begin
               checkOutput("dma_read_data", dmaRdata, rdQ.pop_front());
            end
         end
      end
   end

   // DIVIDER=8 instance: a step only in phase 7 and a quiet bus in phases 4..6.
   always @(negedge clk) begin
      int ph8;
      if (d8On && !rst) begin
         ph8 = tbCycle % DIV8;
         checkOutput("d8_step_phase", {d8Enable, d8Ready}, (ph8 == DIV8 - 1) ? 2'b11 : 2'b00);
         if (ph8 >= 4 && ph8 <= 6) begin
            checkOutput("d8_idle_we", d8MemWe, 1'b0);
            checkOutput("d8_idle_pulse", {d8Ack, d8Rvalid}, 2'b00);
         end
      end
   end

   // One bus frame, entered and left just after the edge that starts phase 0.
   // dmaMode: 0 = no request, 1 = held from phase 0 (served), 2 = raised in
   // phase 2 only (too late for this frame).
   task automatic applyStimulus(input logic halt, input logic we,
                                input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input int dmaMode, input logic [AW-1:0] da,
                                input logic dwe, input logic [DW-1:0] dd);
      if (!halt) begin
         cpuQ.push_back(refMem[a]);
         lastDbi = refMem[a];
         if (we) begin
            refMem[a] = d;
            wrQ.push_back({a, d});
         end
      end
      if (dmaMode == 1) begin
         ackQ.push_back(da);
         if (dwe) begin
            refMem[da] = dd;
            wrQ.push_back({da, dd});
         end else begin
            rdQ.push_back(refMem[da]);
         end
      end
      cpuHalt  = halt;
      cpuWe    = we;
      cpuAb    = a;
      cpuDbo   = d;
      dmaReq   = (dmaMode == 1);
      dmaAddr  = da;
      dmaWe    = dwe;
      dmaWdata = dd;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      if (halt) begin
         checkOutput("halt_dbi_stable", cpuDbi, lastDbi);
      end
      if (dmaMode == 2) begin
         dmaReq = 1'b1;
      end
      repeat (DIV - 2) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_enable"}, cpuEnable, 1'b0);
      checkOutput({tag, "_ready"}, cpuReady, 1'b0);
      checkOutput({tag, "_dma_ack"}, dmaAck, 1'b0);
      checkOutput({tag, "_dma_rvalid"}, dmaRvalid, 1'b0);
      checkOutput({tag, "_mem_we"}, memWe, 1'b0);
      checkOutput({tag, "_mem_addr"}, memAddr, 16'h0000);
      checkOutput({tag, "_mem_wdata"}, memWdata, 8'h00);
      checkOutput({tag, "_cpu_dbi"}, cpuDbi, 8'h00);
      checkOutput({tag, "_dma_rdata"}, dmaRdata, 8'h00);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [AW-1:0] ra, rda;
      for (int i = 0; i < 65536; i++) begin
         ram[i]    = initVal(i);
         refMem[i] = initVal(i);
      end
      ram[16'h1234] = 8'hA5;  refMem[16'h1234] = 8'hA5;
      ram[16'h8000] = 8'h3C;  refMem[16'h8000] = 8'h3C;

      cpuHalt = 1'b0; cpuWe = 1'b0; cpuAb = '0; cpuDbo = '0;
      dmaReq = 1'b0; dmaWe = 1'b0; dmaAddr = '0; dmaWdata = '0;
      d8CpuWe = 1'b1; d8Halt = 1'b0; d8Req = 1'b1; d8DmaWe = 1'b1; d8MemRdata = 8'h00;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkResetValues("reset");
      rst   = 1'b0;
      monOn = 1'b1;
      d8On  = 1'b1;

      // Directed frames
      applyStimulus(0, 0, 16'h1234, 8'h00, 0, 16'h0000, 0, 8'h00);
      applyStimulus(0, 1, 16'h0200, 8'h5A, 0, 16'h0000, 0, 8'h00);
      applyStimulus(0, 0, 16'h0200, 8'h00, 0, 16'h0000, 0, 8'h00);
      applyStimulus(0, 0, 16'h1234, 8'h00, 2, 16'h8000, 0, 8'h00);
      applyStimulus(0, 0, 16'h0200, 8'h00, 1, 16'h8000, 0, 8'h00);
      applyStimulus(1, 1, 16'h0201, 8'hEE, 1, 16'h0202, 1, 8'h99);
      applyStimulus(1, 1, 16'h0202, 8'hDD, 1, 16'h0202, 0, 8'h00);
      applyStimulus(1, 1, 16'h0203, 8'hCC, 1, 16'h8000, 0, 8'h00);
      applyStimulus(0, 0, 16'h0202, 8'h00, 0, 16'h0000, 0, 8'h00);

      // Randomised frames over a small address window to force reuse
      for (int f = 0; f < 150; f++) begin
         ra  = 16'h0200 + AW'($urandom_range(0, 7));
         rda = ($urandom_range(0, 3) == 0) ? 16'h8000 + AW'($urandom_range(0, 3))
                                           : 16'h0200 + AW'($urandom_range(0, 7));
         applyStimulus($urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)), ra,
                       8'($urandom), int'($urandom_range(0, 2)), rda,
                       1'($urandom_range(0, 1)), 8'($urandom));
      end
      applyStimulus(1, 0, 16'h0200, 8'h00, 0, 16'h0000, 0, 8'h00);
      applyStimulus(1, 0, 16'h0200, 8'h00, 0, 16'h0000, 0, 8'h00);

      checkOutput("cpu_queue_drained", cpuQ.size(), 0);
      checkOutput("write_queue_drained", wrQ.size(), 0);
      checkOutput("ack_queue_drained", ackQ.size(), 0);
      checkOutput("read_queue_drained", rdQ.size(), 0);
      monOn = 1'b0;

      // Reset during a DMA write slot
      cpuWe    = 1'b0;
      dmaReq   = 1'b1;
      dmaWe    = 1'b1;
      dmaAddr  = 16'h0300;
      dmaWdata = 8'h77;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      checkOutput("dma_write_slot", memWe, 1'b1);
      rst = 1'b1;
      #1;
      checkOutput("reset_cycle_no_write", memWe, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("reset_memory_untouched", ram[16'h0300], refMem[16'h0300]);
      checkResetValues("midreset");
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      checkOutput("rearm_ack", dmaAck, 1'b1);
      checkOutput("rearm_addr", memAddr, 16'h0300);
      checkOutput("rearm_we", memWe, 1'b1);
      checkOutput("rearm_wdata", memWdata, 8'h77);
      dmaReq = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
